ram_sync_param: RTL

RAM_SYNC_PARAM -- requirements
Module: ram_sync_param

---
 rtl/ram_pkg.sv | 30 +++
 rtl/ram_array.sv | 43 ++++
 rtl/ram_sync_param.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Types and constants shared by the synchronous RAM block and its bench.
//   ram_state_e  : top-level FSM states (CLEAR = zero-fill running,
//                  READY = requests accepted)
//   RD_LAT_MIN/MAX : legal read-latency range
//   clamp_lat()  : folds any RD_LAT value into the legal range
// ---------------------------------------------------------------------------
package ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } ram_state_e;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   // Out-of-range latencies collapse to the nearest legal value, so the
   // pipeline depth is always 1 or 2.
   function automatic int clamp_lat(input int lat);
      if (lat < RD_LAT_MIN) begin
         return RD_LAT_MIN;
      end else if (lat > RD_LAT_MAX) begin
         return RD_LAT_MAX;
      end
      return lat;
   endfunction

endpackage : ram_pkg

// File: rtl/ram_array.sv
// ---------------------------------------------------------------------------
// ram_array
// Single-port storage: synchronous write, registered read, no reset.
// A read and a write at the same edge to the same address return the old
// word (read-before-write).
//   clk      in   clock
//   i_we     in   write enable
//   i_addr   in   word address (read and write share the port)
//   i_wdata  in   write data
//   i_re     in   read enable; o_rdata updates only on an enabled read
//   o_rdata  out  registered read data
// ---------------------------------------------------------------------------
module ram_array
   import ram_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule : ram_array

// File: rtl/ram_sync_param.sv
// ---------------------------------------------------------------------------
// ram_sync_param
// Parameterised synchronous RAM with a zero-fill engine and a fixed-latency
// read pipeline.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready does not depend on req_valid. A request
// presented while req_ready = 0 is not stored; the requester keeps it
// asserted until it transfers. Writes produce no response. A read accepted
// at edge N raises rsp_valid for exactly one cycle, RD_LAT cycles later,
// with the word sampled at edge N; responses come back in issue order.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted this cycle
//   req_wr     in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   clr        in   synchronous request to zero-fill the array
//   rsp_valid  out  one-cycle pulse with read data
//   rsp_rdata  out  read data, holds last value while rsp_valid = 0
//   busy       out  zero-fill in progress
//   dbg_state  out  current FSM state
// ---------------------------------------------------------------------------
module ram_sync_param
   import ram_pkg::*;
#(
   parameter int DATA_W         = 8,
   parameter int ADDR_W         = 8,
   parameter int RD_LAT         = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              clr,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output ram_state_e        dbg_state
);

   localparam int                LAT       = clamp_lat(RD_LAT);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam ram_state_e        RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

   ram_state_e        r_state;
   ram_state_e        w_state_nxt;
   logic [ADDR_W-1:0] r_fill_cnt;
   logic [ADDR_W-1:0] w_fill_cnt_nxt;
   logic              w_busy;
   logic              w_ready_raw;

   logic              w_accept;
   logic              w_rd_acc;
   logic              w_wr_acc;
   logic              w_fill_we;

   logic              w_arr_we;
   logic [ADDR_W-1:0] w_arr_addr;
   logic [DATA_W-1:0] w_arr_wdata;
   logic [DATA_W-1:0] w_arr_rdata;

   logic              w_out_vld;
   logic [DATA_W-1:0] w_out_data;
   logic [DATA_W-1:0] r_rsp_hold;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= RST_STATE;
         r_fill_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_fill_cnt <= w_fill_cnt_nxt;
      end
   end

   // ---------------- FSM: next state and outputs ----------------
   always_comb begin
      w_state_nxt    = r_state;
      w_fill_cnt_nxt = r_fill_cnt;
      w_busy         = 1'b0;
      w_ready_raw    = 1'b0;
      case (r_state)
         CLEAR: begin
            // clr is ignored here; the fill always runs to the last word.
            w_busy = 1'b1;
            if (r_fill_cnt == LAST_ADDR) begin
               w_state_nxt    = READY;
               w_fill_cnt_nxt = '0;
            end else begin
               w_fill_cnt_nxt = r_fill_cnt + 1'b1;
            end
         end
         READY: begin
            w_ready_raw = !clr;
            if (clr) begin
               w_state_nxt    = CLEAR;
               w_fill_cnt_nxt = '0;
            end
         end
         default: begin
            w_state_nxt    = RST_STATE;
            w_fill_cnt_nxt = '0;
         end
      endcase
   end

   // With CLEAR_ON_RESET = 0 the state sits in READY during reset, so
   // req_ready is masked by rst directly.
   assign req_ready = w_ready_raw && !rst;
   assign busy      = w_busy;
   assign dbg_state = r_state;

   // ---------------- request arbitration ----------------
   assign w_accept  = req_valid && req_ready;
   assign w_rd_acc  = w_accept && !req_wr;
   assign w_wr_acc  = w_accept &&  req_wr;
   assign w_fill_we = w_busy && !rst;

   // The fill engine owns the port while busy; requests are blocked then,
   // so the two write sources never collide.
   assign w_arr_we    = w_fill_we || w_wr_acc;
   assign w_arr_addr  = w_busy ? r_fill_cnt : req_addr;
   assign w_arr_wdata = w_busy ? '0 : req_wdata;

   ram_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram_array (
      .clk     (clk),
      .i_we    (w_arr_we),
      .i_addr  (w_arr_addr),
      .i_wdata (w_arr_wdata),
      .i_re    (w_rd_acc),
      .o_rdata (w_arr_rdata)
   );

   // ---------------- read latency pipeline ----------------
   // The array register already provides one cycle; a second stage is added
   // only for LAT = 2. The array output holds while no read is accepted, so
   // in-flight data survives the start of a fill.
   generate
      if (LAT == 1) begin : g_lat1
         logic r_vld_s1;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_vld_s1 <= 1'b0;
            end else begin
               r_vld_s1 <= w_rd_acc;
            end
         end

         assign w_out_vld  = r_vld_s1;
         assign w_out_data = w_arr_rdata;
      end else begin : g_lat2
         logic              r_vld_s1;
         logic              r_vld_s2;
         logic [DATA_W-1:0] r_data_s2;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_vld_s1  <= 1'b0;
               r_vld_s2  <= 1'b0;
               r_data_s2 <= '0;
            end else begin
               r_vld_s1 <= w_rd_acc;
               r_vld_s2 <= r_vld_s1;
               if (r_vld_s1) begin
                  r_data_s2 <= w_arr_rdata;
               end
            end
         end

         assign w_out_vld  = r_vld_s2;
         assign w_out_data = r_data_s2;
      end
   endgenerate

   // Last delivered word; shown on rsp_rdata between responses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_hold <= '0;
      end else if (w_out_vld) begin
         r_rsp_hold <= w_out_data;
      end
   end

   assign rsp_valid = w_out_vld;
   assign rsp_rdata = w_out_vld ? w_out_data : r_rsp_hold;

endmodule : ram_sync_param
